// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Stream test-pattern frame source.
// Emits one width x height frame per accepted fsync: tuser on pixel (0,0), tlast at the
// end of every line, optional blanking cycles between lines.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   fsync                            frame start request
//   width, height, pattern, color    frame setup, latched at frame start
//   m_axis_tvalid/tdata/tuser/tlast  AXIS master beat
//   m_axis_tready                    AXIS ready from the sink
//   busy, frame_done, overrun        frame status
module axis_pattern_gen #(
   parameter int unsigned C_PIXEL_WIDTH = 8,
   parameter int unsigned C_RESO_WIDTH  = 10,
   parameter int unsigned C_CH0_WIDTH   = 8,
   parameter int unsigned C_CH1_WIDTH   = 0,
   parameter int unsigned C_CH2_WIDTH   = 0,
   parameter int unsigned C_CHECK_SHIFT = 3,
   parameter int unsigned C_HBLANK      = 0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     fsync,
   input  logic [C_RESO_WIDTH-1:0]  width,
   input  logic [C_RESO_WIDTH-1:0]  height,
   input  logic [2:0]               pattern,
   input  logic [C_PIXEL_WIDTH-1:0] color,
   output logic                     m_axis_tvalid,
   output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overrun
);

   localparam int unsigned PW   = C_PIXEL_WIDTH;
   localparam int unsigned RW   = C_RESO_WIDTH;
   localparam int unsigned HB_W = (C_HBLANK > 1) ? $clog2(C_HBLANK) : 1;
   localparam logic [63:0] M0   = (64'd1 << C_CH0_WIDTH) - 64'd1;
   localparam logic [63:0] M1   = (64'd1 << C_CH1_WIDTH) - 64'd1;
   localparam logic [63:0] M2   = (64'd1 << C_CH2_WIDTH) - 64'd1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HBLANK} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
   logic [PW-1:0]   n_q, n_d, col_q, col_d;
   logic [2:0]      pat_q, pat_d;
   logic [HB_W-1:0] hb_q, hb_d;
   logic            pend_q, pend_d, ovr_q, ovr_d, busy_q, busy_d, done_q, done_d;
   logic            vld_q, vld_d, user_q, user_d, last_q, last_d;
   logic [PW-1:0]   data_q, data_d;
   logic            hs, eol, eof, geom_ok, start, present;

   // Copy a value into every present channel, each truncated to its own width.
   function automatic logic [PW-1:0] replicate(input logic [63:0] v);
      logic [63:0] r;
      r = (v & M0)
        | ((v & M1) << C_CH0_WIDTH)
        | ((v & M2) << (C_CH0_WIDTH + C_CH1_WIDTH));
      return PW'(r);
   endfunction

   // Pixel value for coordinate (px,py) with running pixel index pn.
   function automatic logic [PW-1:0] pixel(input logic [RW-1:0] px, input logic [RW-1:0] py,
                                           input logic [PW-1:0] pn, input logic [2:0] pat,
                                           input logic [PW-1:0] col);
      logic [RW-1:0] cx, cy;
      cx = px >> C_CHECK_SHIFT;
      cy = py >> C_CHECK_SHIFT;
      case (pat)
         3'd1:    return replicate(64'(px));
         3'd2:    return replicate(64'(py));
         3'd3:    return (cx[0] ^ cy[0]) ? '1 : col;
         3'd4:    return replicate(64'(pn));
         default: return col;
      endcase
   endfunction

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      n_d     = n_q;
      w_d     = w_q;
      h_d     = h_q;
      pat_d   = pat_q;
      col_d   = col_q;
      hb_d    = hb_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      vld_d   = vld_q;
      data_d  = data_q;
      user_d  = user_q;
      last_d  = last_q;
      start   = 1'b0;
      present = 1'b0;

      hs      = vld_q & m_axis_tready;
      eol     = (x_q == w_q - RW'(1));
      eof     = eol && (y_q == h_q - RW'(1));
      geom_ok = (width != '0) && (height != '0);

      // One-deep pending request while a frame is in flight; a second request is dropped.
      if (state_q != S_IDLE && fsync) begin
         if (pend_q) ovr_d  = 1'b1;
         else        pend_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (fsync && geom_ok) start = 1'b1;
         end
         S_LOAD: begin
            state_d = S_RUN;
            present = 1'b1;
         end
         S_RUN: begin
            if (hs) begin
               if (eof) begin
                  vld_d   = 1'b0;
                  user_d  = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  pend_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
                  // fsync at this very edge behaves as a pending request.
                  if ((pend_q || fsync) && geom_ok) start = 1'b1;
               end else if (eol) begin
                  x_d = '0;
                  y_d = y_q + RW'(1);
                  n_d = n_q + PW'(1);
                  if (C_HBLANK > 0) begin
                     vld_d   = 1'b0;
                     user_d  = 1'b0;
                     last_d  = 1'b0;
                     hb_d    = '0;
                     state_d = S_HBLANK;
                  end else begin
                     present = 1'b1;
                  end
               end else begin
                  x_d     = x_q + RW'(1);
                  n_d     = n_q + PW'(1);
                  present = 1'b1;
               end
            end
         end
         S_HBLANK: begin
            hb_d = hb_q + HB_W'(1);
            if (32'(hb_q) + 32'd1 >= C_HBLANK) begin
               state_d = S_RUN;
               present = 1'b1;
            end
         end
      endcase

      if (start) begin
         w_d     = width;
         h_d     = height;
         pat_d   = pattern;
         col_d   = color;
         x_d     = '0;
         y_d     = '0;
         n_d     = '0;
         busy_d  = 1'b1;
         state_d = S_LOAD;
      end

      if (present) begin
         vld_d  = 1'b1;
         data_d = pixel(x_d, y_d, n_d, pat_d, col_d);
         user_d = (x_d == '0) && (y_d == '0);
         last_d = (x_d == w_d - RW'(1));
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         n_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         pat_q   <= '0;
         col_q   <= '0;
         hb_q    <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         user_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         n_q     <= n_d;
         w_q     <= w_d;
         h_q     <= h_d;
         pat_q   <= pat_d;
         col_q   <= col_d;
         hb_q    <= hb_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         user_q  <= user_d;
         last_q  <= last_d;
      end
   end

   assign m_axis_tvalid = vld_q;
   assign m_axis_tdata  = data_q;
   assign m_axis_tuser  = user_q;
   assign m_axis_tlast  = last_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: randomized bench for axis_pattern_gen against a frame-level model.
// The model expands each requested frame into its expected beats (value, tuser, tlast,
// idle cycles expected before the beat); a negedge monitor compares every handshake,
// stall stability, inter-beat gaps and frame_done against it.
module tb_axis_pattern_gen;

   localparam int CS = 1;
   localparam int HB = 2;

   typedef struct {
      logic [7:0] d;
      logic       u;
      logic       l;
      logic       fl;
      int         gap;
   } beat_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       fsync = 1'b0;
   logic [9:0] width = '0;
   logic [9:0] height = '0;
   logic [2:0] pattern = '0;
   logic [7:0] color = '0;
   logic       m_axis_tvalid;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tuser;
   logic       m_axis_tlast;
   logic       m_axis_tready = 1'b1;
   logic       busy, frame_done, overrun;

   beat_t      q[$];
   int         checks = 0;
   int         errors = 0;
   int         idle_run = 0;
   int         done_cnt = 0;
   bit         rand_ready = 1'b0;
   bit         exp_done = 1'b0;
   bit         prev_valid = 1'b0;
   bit         prev_hs = 1'b0;
   logic [9:0] prev_bus = '0;

   axis_pattern_gen #(
      .C_PIXEL_WIDTH(8), .C_RESO_WIDTH(10), .C_CH0_WIDTH(8), .C_CH1_WIDTH(0),
      .C_CH2_WIDTH(0), .C_CHECK_SHIFT(CS), .C_HBLANK(HB)
   ) dut (
      .clk(clk), .resetn(resetn), .fsync(fsync), .width(width), .height(height),
      .pattern(pattern), .color(color), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_pix(int x, int y, int w, int pat, logic [7:0] col);
      int n;
      n = y * w + x;
      case (pat)
         1:       return 8'(x);
         2:       return 8'(y);
         3:       return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 8'hFF : col;
         4:       return 8'(n % 256);
         default: return col;
      endcase
   endfunction

   // Expand one frame into expected beats; first_gap < 0 means unconstrained.
   task automatic push_frame(int w, int h, int pat, logic [7:0] col, int first_gap);
      beat_t b;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            b.d   = model_pix(x, y, w, pat, col);
            b.u   = (x == 0 && y == 0);
            b.l   = (x == w - 1);
            b.fl  = (x == w - 1 && y == h - 1);
            b.gap = (x == 0 && y == 0) ? first_gap : (x == 0) ? HB : 0;
            q.push_back(b);
         end
      end
   endtask

   task automatic start_frame(int w, int h, int pat, logic [7:0] col, int fs_cycles);
      @(negedge clk);
      width   = 10'(w);
      height  = 10'(h);
      pattern = 3'(pat);
      color   = col;
      fsync   = 1'b1;
      repeat (fs_cycles) @(negedge clk);
      fsync   = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((q.size() != 0 || busy || exp_done) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check_eq("queue_drained", q.size(), 0);
      check_eq("busy_after", busy, 0);
   endtask

   // Monitor: outputs sampled on the falling edge; tready chosen here for the next rising edge.
   always @(negedge clk) begin
      m_axis_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (resetn) begin
         check_eq("frame_done", frame_done, exp_done);
         exp_done = 1'b0;
         if (frame_done) done_cnt++;
         if (m_axis_tvalid) begin
            if (!prev_valid || prev_hs) begin
               if (q.size() == 0) check_eq("extra_beat", m_axis_tvalid, 0);
               else if (q[0].gap >= 0) check_eq("gap", idle_run, q[0].gap);
            end else begin
               check_eq("stall_stable", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, prev_bus);
            end
            if (m_axis_tready && q.size() != 0) begin
               check_eq("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast},
                        {q[0].d, q[0].u, q[0].l});
               if (q[0].fl) exp_done = 1'b1;
               void'(q.pop_front());
            end
            idle_run = 0;
         end else begin
            idle_run++;
         end
         prev_valid = m_axis_tvalid;
         prev_hs    = m_axis_tvalid & m_axis_tready;
         prev_bus   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
   end

   initial begin
      int d0, w, h, p;
      repeat (3) @(negedge clk);
      check_eq("rst_tvalid", m_axis_tvalid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_flags", {frame_done, overrun, m_axis_tuser, m_axis_tlast}, 0);
      resetn = 1'b1;

      // Hramp frame, always ready.
      d0 = done_cnt;
      push_frame(4, 2, 1, 8'h00, -1);
      start_frame(4, 2, 1, 8'h00, 1);
      wait_idle();
      check_eq("t1_done_once", done_cnt - d0, 1);

      // Same frame with back-pressure.
      rand_ready = 1'b1;
      push_frame(4, 2, 1, 8'h00, -1);
      start_frame(4, 2, 1, 8'h00, 1);
      wait_idle();

      // Zero width is ignored.
      start_frame(0, 2, 1, 8'h00, 1);
      repeat (4) begin
         @(negedge clk);
         check_eq("zw_busy", busy, 0);
         check_eq("zw_tvalid", m_axis_tvalid, 0);
      end
      check_eq("zw_overrun", overrun, 0);

      // Checker with shift 1.
      push_frame(4, 1, 3, 8'h10, -1);
      start_frame(4, 1, 3, 8'h10, 1);
      wait_idle();

      // Horizontal blanking between lines only.
      push_frame(2, 3, 2, 8'h00, -1);
      start_frame(2, 3, 2, 8'h00, 1);
      wait_idle();

      // Random frames under random back-pressure.
      for (int i = 0; i < 25; i++) begin
         w = $urandom_range(1, 7);
         h = $urandom_range(1, 4);
         p = $urandom_range(0, 7);
         d0 = $urandom_range(0, 255);
         push_frame(w, h, p, 8'(d0), -1);
         start_frame(w, h, p, 8'(d0), 1);
         wait_idle();
      end
      check_eq("no_overrun_yet", overrun, 0);

      // fsync held three cycles: one start, one pending, one dropped.
      d0 = done_cnt;
      push_frame(3, 1, 4, 8'h00, -1);
      push_frame(3, 1, 4, 8'h00, 1);
      start_frame(3, 1, 4, 8'h00, 3);
      wait_idle();
      repeat (5) @(negedge clk);
      check_eq("t3_frames", done_cnt - d0, 2);
      check_eq("t3_overrun", overrun, 1);
      check_eq("t3_idle_tvalid", m_axis_tvalid, 0);

      // Asynchronous reset in the middle of a line.
      rand_ready = 1'b0;
      push_frame(6, 2, 1, 8'h00, -1);
      start_frame(6, 2, 1, 8'h00, 1);
      for (int t = 0; t < 100 && q.size() > 9; t++) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check_eq("mid_rst_tvalid", m_axis_tvalid, 0);
      check_eq("mid_rst_data", m_axis_tdata, 0);
      check_eq("mid_rst_flags", {m_axis_tuser, m_axis_tlast, busy, frame_done, overrun}, 0);
      q.delete();
      exp_done   = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      idle_run   = 0;
      @(negedge clk);
      resetn = 1'b1;
      push_frame(2, 1, 2, 8'h00, -1);
      start_frame(2, 1, 2, 8'h00, 1);
      wait_idle();
      check_eq("post_rst_overrun", overrun, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
